fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch (IF) stage of the pipelined RV32I core. Holds the PC and drives the word-aligned fetch address
//   to the combinational instruction memory. Registers the returned instruction into the IF/ID pipeline register.
//   Predicts next PC from a direct-mapped BTB with 2-bit saturating counters; trained and redirected by EX.
// PARAMETERS
//   RESET_PC     32'h0000_0000  PC value loaded on reset
//   BTB_ENTRIES  16             BTB depth; power of 2, >=2; IDX_W = log2(BTB_ENTRIES), TAG_W = 30-IDX_W
// PORTS
//   i_clk          in   1   clock, rising edge
//   i_rst_n        in   1   asynchronous active-low reset
//   i_stall        in   1   hazard stall from ID: hold PC and IF/ID
//   i_redirect     in   1   EX mispredict: load i_redirect_pc, flush IF/ID
//   i_redirect_pc  in   32  corrected PC from EX
//   i_upd_en       in   1   EX resolved a branch/jump this cycle
//   i_upd_pc       in   32  PC of resolved branch
//   i_upd_taken    in   1   actual outcome
//   i_upd_target   in   32  actual target
//   o_addr_inst    out  32  fetch address to instruction memory (= PC register)
//   i_inst         in   32  instruction returned by memory (same cycle)
//   o_if_id_valid  out  1   IF/ID holds a real instruction
//   o_if_id_pc     out  32  PC of IF/ID instruction
//   o_if_id_inst   out  32  IF/ID instruction
//   o_if_id_pred   out  1   fetch was predicted taken
//   o_if_id_ptgt   out  32  predicted next PC used at fetch (for EX compare)
// BEHAVIOUR
//   - Reset (async, i_rst_n=0): PC=RESET_PC; IF/ID valid=0, pc=0, inst=32'h0000_0013 (NOP), pred=0, ptgt=0;
//     all BTB valid=0, counters=2'b01. Reset asserted mid-operation discards all in-flight state immediately.
//   - o_addr_inst = PC, combinational; PC[1:0] always 00 (low bits of any loaded value forced to 0).
//   - Lookup: idx = PC[IDX_W+1:2], tag = PC[31:IDX_W+2]; hit = valid & tag match; pred = hit & ctr[1].
//     pnext = pred ? target : PC+4 (mod 2^32, 0xFFFF_FFFC wraps to 0).
//   - Next PC priority per edge: i_redirect -> i_redirect_pc; else i_stall -> hold; else pnext.
//   - IF/ID: i_redirect -> valid=0, inst=NOP, pred=0 (flush wins over stall);
//     else i_stall -> hold all; else capture {1, PC, i_inst, pred, pnext}.
//   - Latency: address out in cycle N, instruction visible on IF/ID outputs in cycle N+1.
//   - BTB update on i_upd_en (independent of stall/redirect):
//       hit & taken: ctr=sat_inc(ctr), target=i_upd_target; hit & not-taken: ctr=sat_dec(ctr);
//       miss & taken: allocate (overwrite) valid=1, tag, target, ctr=2'b10; miss & not-taken: no change.
//     Counters saturate at 2'b11 / 2'b00. Same-cycle lookup of an entry being updated sees the OLD contents.
//   - Aliasing: different tag at same idx is a miss; allocation evicts the previous entry.
// CONFIGURATION
//   BRANCH_PREDICT_EN defined: BTB and counters built; prediction as above.
//   Not defined: no BTB storage; pred=0, pnext=PC+4 always; update ports ignored; i_redirect still honoured.
// TESTING
//   1 Reset release, no stall: o_addr_inst 0x0,0x4,0x8; o_if_id_valid=0 first cycle, then pc 0x0 with i_inst.
//   2 i_stall high 3 cycles at PC 0x8: o_addr_inst stays 0x8, IF/ID outputs unchanged; resumes 0xC.
//   3 i_stall=1 and i_redirect=1 to 0x103: next o_addr_inst=0x100, o_if_id_valid=0, inst=0x13.
//   4 Update pc 0x20 taken tgt 0x80: fetch of 0x20 -> o_if_id_pred=1, next addr 0x80; two not-taken
//     updates -> ctr 00, fetch of 0x20 -> next addr 0x24, pred=0.
//   5 BTB_ENTRIES=16: train 0x20 taken, fetch 0x60 (same idx, other tag) -> pred=0, next 0x64;
//     train 0x60 taken -> 0x20 now misses.
//   6 Macro undefined: repeat scenario 4 -> always PC+4, o_if_id_pred=0; PC 0xFFFF_FFFC wraps to 0x0.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: control and training inputs from ID/EX, the instruction-memory port, and IF/ID outputs.
interface fetch_stage_if;
  logic        i_stall;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_upd_en;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic [31:0] o_addr_inst;
  logic [31:0] i_inst;
  logic        o_if_id_valid;
  logic [31:0] o_if_id_pc;
  logic [31:0] o_if_id_inst;
  logic        o_if_id_pred;
  logic [31:0] o_if_id_ptgt;

  modport slave (
    input  i_stall, i_redirect, i_redirect_pc, i_upd_en, i_upd_pc, i_upd_taken, i_upd_target, i_inst,
    output o_addr_inst, o_if_id_valid, o_if_id_pc, o_if_id_inst, o_if_id_pred, o_if_id_ptgt
  );

  modport master (
    output i_stall, i_redirect, i_redirect_pc, i_upd_en, i_upd_pc, i_upd_taken, i_upd_target, i_inst,
    input  o_addr_inst, o_if_id_valid, o_if_id_pc, o_if_id_inst, o_if_id_pred, o_if_id_ptgt
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC register, IF/ID pipeline register, optional direct-mapped BTB.
// Define BRANCH_PREDICT_EN to build the BTB with 2-bit counters; otherwise next PC is always PC+4.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BTB_ENTRIES = 16
) (
  input logic          i_clk,
  input logic          i_rst_n,
  fetch_stage_if.slave bus
);

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ALIGN_MSK = 32'hFFFF_FFFC;

  logic [31:0] pc_q, pc_d;
  logic        v_q, v_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] inst_q, inst_d;
  logic        pred_q, pred_d;
  logic [31:0] ptgt_q, ptgt_d;

  logic        pred_c;
  logic [31:0] pnext_c;

`ifdef BRANCH_PREDICT_EN
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic             valid_q [BTB_ENTRIES];
  logic [TAG_W-1:0] tag_q   [BTB_ENTRIES];
  logic [29:0]      tgt_q   [BTB_ENTRIES];
  logic [1:0]       ctr_q   [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             up_hit, up_we;
  logic [1:0]       ctr_d;
  logic [29:0]      tgt_d;
  logic             unused_lsb;

  assign lk_idx     = pc_q[IDX_W+1:2];
  assign lk_tag     = pc_q[31:IDX_W+2];
  assign up_idx     = bus.i_upd_pc[IDX_W+1:2];
  assign up_tag     = bus.i_upd_pc[31:IDX_W+2];
  assign unused_lsb = ^{bus.i_upd_pc[1:0], bus.i_upd_target[1:0]};

  // Lookup reads registered contents, so a same-cycle update is not visible here
  always_comb begin
    pred_c  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][1];
    pnext_c = pred_c ? {tgt_q[lk_idx], 2'b00} : pc_q + 32'd4;
  end

  // Training: hit adjusts the counter, taken miss allocates over whatever sits at the index
  always_comb begin
    up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_we  = 1'b0;
    ctr_d  = ctr_q[up_idx];
    tgt_d  = tgt_q[up_idx];
    if (bus.i_upd_en) begin
      if (up_hit) begin
        up_we = 1'b1;
        if (bus.i_upd_taken) begin
          ctr_d = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
          tgt_d = bus.i_upd_target[31:2];
        end else begin
          ctr_d = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
        end
      end else if (bus.i_upd_taken) begin
        up_we = 1'b1;
        ctr_d = 2'b10;
        tgt_d = bus.i_upd_target[31:2];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (up_we) begin
      valid_q[up_idx] <= 1'b1;
      tag_q[up_idx]   <= up_tag;
      tgt_q[up_idx]   <= tgt_d;
      ctr_q[up_idx]   <= ctr_d;
    end
  end
`else
  localparam int unsigned unused_btb_entries = BTB_ENTRIES;
  logic unused_upd;

  assign unused_upd = ^{bus.i_upd_en, bus.i_upd_pc, bus.i_upd_taken, bus.i_upd_target};
  assign pred_c     = 1'b0;
  assign pnext_c    = pc_q + 32'd4;
`endif

  // Next PC and IF/ID: redirect (flush) beats stall, stall beats normal advance
  always_comb begin
    pc_d    = pc_q;
    v_d     = v_q;
    id_pc_d = id_pc_q;
    inst_d  = inst_q;
    pred_d  = pred_q;
    ptgt_d  = ptgt_q;
    if (bus.i_redirect) begin
      pc_d   = bus.i_redirect_pc & ALIGN_MSK;
      v_d    = 1'b0;
      inst_d = NOP;
      pred_d = 1'b0;
    end else if (!bus.i_stall) begin
      pc_d    = pnext_c & ALIGN_MSK;
      v_d     = 1'b1;
      id_pc_d = pc_q;
      inst_d  = bus.i_inst;
      pred_d  = pred_c;
      ptgt_d  = pnext_c;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pc_q    <= RESET_PC & ALIGN_MSK;
      v_q     <= 1'b0;
      id_pc_q <= '0;
      inst_q  <= NOP;
      pred_q  <= 1'b0;
      ptgt_q  <= '0;
    end else begin
      pc_q    <= pc_d;
      v_q     <= v_d;
      id_pc_q <= id_pc_d;
      inst_q  <= inst_d;
      pred_q  <= pred_d;
      ptgt_q  <= ptgt_d;
    end
  end

  assign bus.o_addr_inst   = pc_q;
  assign bus.o_if_id_valid = v_q;
  assign bus.o_if_id_pc    = id_pc_q;
  assign bus.o_if_id_inst  = inst_q;
  assign bus.o_if_id_pred  = pred_q;
  assign bus.o_if_id_ptgt  = ptgt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: vector table plus hand-written BTB sequences, checked through a scoreboard queue.
module tb_fetch_stage;

  logic clk;
  logic rst_n;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .BTB_ENTRIES(16)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_t;
    logic [31:0] upd_tgt;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        meta;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_pred;
    logic [31:0] e_ptgt;
  } vec_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  int   n_vec = 0;
  int   n_mis = 0;
  int   cur   = 0;
  vec_t sb[$];
  vec_t tbl[13];

  function automatic logic [31:0] inst_fn(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  assign bus.i_inst = inst_fn(bus.o_addr_inst);

  function automatic vec_t nv(input logic st, input logic rd, input logic [31:0] rpc);
    vec_t v;
    v = '{default: '0};
    v.stall = st; v.redir = rd; v.rpc = rpc;
    return v;
  endfunction

  function automatic vec_t up(input vec_t vi, input logic [31:0] pc, input logic t, input logic [31:0] tgt);
    vec_t v;
    v = vi;
    v.upd_en = 1'b1; v.upd_pc = pc; v.upd_t = t; v.upd_tgt = tgt;
    return v;
  endfunction

  function automatic vec_t cap(input vec_t vi, input logic [31:0] addr, input logic [31:0] pc,
                               input logic pred, input logic [31:0] ptgt);
    vec_t v;
    v = vi;
    v.e_addr = addr; v.e_valid = 1'b1; v.meta = 1'b1; v.e_pc = pc;
    v.e_inst = inst_fn(pc); v.e_pred = pred; v.e_ptgt = ptgt;
    return v;
  endfunction

  function automatic vec_t fl(input vec_t vi, input logic [31:0] addr);
    vec_t v;
    v = vi;
    v.e_addr = addr; v.e_valid = 1'b0; v.meta = 1'b0; v.e_inst = NOP; v.e_pred = 1'b0;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s vec%0d: got %h want %h", nm, cur, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.i_stall       = v.stall;
    bus.i_redirect    = v.redir;
    bus.i_redirect_pc = v.rpc;
    bus.i_upd_en      = v.upd_en;
    bus.i_upd_pc      = v.upd_pc;
    bus.i_upd_taken   = v.upd_t;
    bus.i_upd_target  = v.upd_tgt;
  endtask

  // Drive one cycle of stimulus, then compare the post-edge state against the queued expectation
  task automatic run_vec(input vec_t v);
    vec_t e;
    drive(v);
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_mis++;
      $display("FAIL scoreboard vec%0d: got empty queue want entry", cur);
    end else begin
      e = sb.pop_front();
      chk("addr", bus.o_addr_inst, e.e_addr);
      chk("valid", 32'(bus.o_if_id_valid), 32'(e.e_valid));
      chk("inst", bus.o_if_id_inst, e.e_inst);
      chk("pred", 32'(bus.o_if_id_pred), 32'(e.e_pred));
      if (e.meta) begin
        chk("pc", bus.o_if_id_pc, e.e_pc);
        chk("ptgt", bus.o_if_id_ptgt, e.e_ptgt);
      end
    end
    cur++;
  endtask

  task automatic chk_reset();
    chk("rst_addr", bus.o_addr_inst, 32'h0);
    chk("rst_valid", 32'(bus.o_if_id_valid), 32'h0);
    chk("rst_pc", bus.o_if_id_pc, 32'h0);
    chk("rst_inst", bus.o_if_id_inst, NOP);
    chk("rst_pred", 32'(bus.o_if_id_pred), 32'h0);
    chk("rst_ptgt", bus.o_if_id_ptgt, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t n0;
    n0 = nv(1'b0, 1'b0, 32'h0);

    tbl[0]  = cap(n0, 32'h4, 32'h0, 1'b0, 32'h4);
    tbl[1]  = cap(n0, 32'h8, 32'h4, 1'b0, 32'h8);
    tbl[2]  = cap(nv(1'b1, 1'b0, 32'h0), 32'h8, 32'h4, 1'b0, 32'h8);
    tbl[3]  = cap(nv(1'b1, 1'b0, 32'h0), 32'h8, 32'h4, 1'b0, 32'h8);
    tbl[4]  = cap(nv(1'b1, 1'b0, 32'h0), 32'h8, 32'h4, 1'b0, 32'h8);
    tbl[5]  = cap(n0, 32'hC, 32'h8, 1'b0, 32'hC);
    tbl[6]  = fl(nv(1'b1, 1'b1, 32'h103), 32'h100);
    tbl[7]  = cap(n0, 32'h104, 32'h100, 1'b0, 32'h104);
    tbl[8]  = fl(nv(1'b0, 1'b1, 32'h200), 32'h200);
    tbl[9]  = cap(n0, 32'h204, 32'h200, 1'b0, 32'h204);
    tbl[10] = fl(nv(1'b0, 1'b1, 32'hFFFF_FFFC), 32'hFFFF_FFFC);
    tbl[11] = cap(n0, 32'h0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tbl[12] = cap(n0, 32'h4, 32'h0, 1'b0, 32'h4);

    rst_n = 1'b0;
    drive(n0);
    #12;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

`ifdef BRANCH_PREDICT_EN
    // Allocate 0x20 -> 0x80, predict, then two not-taken updates drop it below threshold
    run_vec(fl(up(nv(1'b0, 1'b1, 32'h40), 32'h20, 1'b1, 32'h80), 32'h40));
    run_vec(fl(nv(1'b0, 1'b1, 32'h20), 32'h20));
    run_vec(cap(n0, 32'h80, 32'h20, 1'b1, 32'h80));
    run_vec(cap(n0, 32'h84, 32'h80, 1'b0, 32'h84));
    run_vec(cap(up(n0, 32'h20, 1'b0, 32'h0), 32'h88, 32'h84, 1'b0, 32'h88));
    run_vec(cap(up(n0, 32'h20, 1'b0, 32'h0), 32'h8C, 32'h88, 1'b0, 32'h8C));
    run_vec(fl(nv(1'b0, 1'b1, 32'h20), 32'h20));
    run_vec(cap(n0, 32'h24, 32'h20, 1'b0, 32'h24));
    // Aliasing at index 8: 0x60 misses against 0x20, then evicts it
    run_vec(cap(up(n0, 32'h20, 1'b1, 32'h80), 32'h28, 32'h24, 1'b0, 32'h28));
    run_vec(cap(up(n0, 32'h20, 1'b1, 32'h80), 32'h2C, 32'h28, 1'b0, 32'h2C));
    run_vec(fl(nv(1'b0, 1'b1, 32'h60), 32'h60));
    run_vec(cap(n0, 32'h64, 32'h60, 1'b0, 32'h64));
    run_vec(fl(nv(1'b0, 1'b1, 32'h20), 32'h20));
    run_vec(cap(n0, 32'h80, 32'h20, 1'b1, 32'h80));
    run_vec(cap(up(n0, 32'h60, 1'b1, 32'h300), 32'h84, 32'h80, 1'b0, 32'h84));
    run_vec(fl(nv(1'b0, 1'b1, 32'h20), 32'h20));
    run_vec(cap(n0, 32'h24, 32'h20, 1'b0, 32'h24));
    // Same-cycle update is invisible to the lookup of that entry
    run_vec(fl(nv(1'b0, 1'b1, 32'h60), 32'h60));
    run_vec(cap(up(n0, 32'h60, 1'b0, 32'h0), 32'h300, 32'h60, 1'b1, 32'h300));
    run_vec(fl(nv(1'b0, 1'b1, 32'h60), 32'h60));
    run_vec(cap(n0, 32'h64, 32'h60, 1'b0, 32'h64));
    // Saturation at 11: three taken then one not-taken still predicts taken
    run_vec(cap(up(n0, 32'h60, 1'b1, 32'h300), 32'h68, 32'h64, 1'b0, 32'h68));
    run_vec(cap(up(n0, 32'h60, 1'b1, 32'h300), 32'h6C, 32'h68, 1'b0, 32'h6C));
    run_vec(cap(up(n0, 32'h60, 1'b1, 32'h300), 32'h70, 32'h6C, 1'b0, 32'h70));
    run_vec(cap(up(n0, 32'h60, 1'b0, 32'h0), 32'h74, 32'h70, 1'b0, 32'h74));
    run_vec(fl(nv(1'b0, 1'b1, 32'h60), 32'h60));
    run_vec(cap(n0, 32'h300, 32'h60, 1'b1, 32'h300));
    // Taken hit retargets the entry
    run_vec(cap(up(n0, 32'h60, 1'b1, 32'h500), 32'h304, 32'h300, 1'b0, 32'h304));
    run_vec(fl(nv(1'b0, 1'b1, 32'h60), 32'h60));
    run_vec(cap(n0, 32'h500, 32'h60, 1'b1, 32'h500));
`else
    // Without prediction, training is ignored and fetch always falls through
    run_vec(fl(up(nv(1'b0, 1'b1, 32'h40), 32'h20, 1'b1, 32'h80), 32'h40));
    run_vec(fl(nv(1'b0, 1'b1, 32'h20), 32'h20));
    run_vec(cap(n0, 32'h24, 32'h20, 1'b0, 32'h24));
    run_vec(cap(n0, 32'h28, 32'h24, 1'b0, 32'h28));
    run_vec(cap(up(n0, 32'h20, 1'b0, 32'h0), 32'h2C, 32'h28, 1'b0, 32'h2C));
    run_vec(cap(up(n0, 32'h20, 1'b0, 32'h0), 32'h30, 32'h2C, 1'b0, 32'h30));
    run_vec(fl(nv(1'b0, 1'b1, 32'h20), 32'h20));
    run_vec(cap(n0, 32'h24, 32'h20, 1'b0, 32'h24));
    run_vec(fl(up(nv(1'b0, 1'b1, 32'h60), 32'h60, 1'b1, 32'h300), 32'h60));
    run_vec(cap(n0, 32'h64, 32'h60, 1'b0, 32'h64));
`endif

    // Mid-run asynchronous reset clears pipeline and predictor state at once
    #2;
    rst_n = 1'b0;
    drive(n0);
    #1;
    chk_reset();
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(cap(n0, 32'h4, 32'h0, 1'b0, 32'h4));
    run_vec(fl(nv(1'b0, 1'b1, 32'h60), 32'h60));
    run_vec(cap(n0, 32'h64, 32'h60, 1'b0, 32'h64));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
